// File: rtl/vote_result_reader.sv
`default_nettype none
// ============================================================================
// Module   : vote_result_reader
// Purpose  : Drains the vote BRAM one slot at a time. Each slot is reduced
//            to an argmax label (classification) or passed through as a raw
//            sum (regression), then streamed out over valid/ready.
// Options  : VOTE_READER_CLEAR_EN - when defined, every word read is cleared
//            through BRAM port B so the buffer starts the next batch at zero.
// Revision : 1.0 - initial release
// ============================================================================
module vote_result_reader #(
  parameter int N_LABELS       = 10,
  parameter int N_LABELS_WIDTH = 4,
  parameter int RES_WIDTH      = 16,
  parameter int BRAM_AWIDTH    = 14,
  parameter int BRAM_DWIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  input  logic [BRAM_AWIDTH-1:0]    i_n_slots,
  input  logic [N_LABELS_WIDTH-1:0] i_n_labels,
  input  logic                      i_is_clf,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_bram_en,
  output logic [BRAM_AWIDTH-1:0]    o_bram_raddr,
  input  logic [BRAM_DWIDTH-1:0]    i_bram_dout,
  output logic                      o_bram_we,
  output logic [BRAM_AWIDTH-1:0]    o_bram_waddr,
  output logic [BRAM_DWIDTH-1:0]    o_bram_din,
  output logic                      o_res_vld,
  input  logic                      i_res_rdy,
  output logic [BRAM_AWIDTH-1:0]    o_res_slot,
  output logic [N_LABELS_WIDTH-1:0] o_res_label,
  output logic [RES_WIDTH-1:0]      o_res_value
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    LAST = 3'd2,
    OUT  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic [BRAM_AWIDTH-1:0]    n_slots_q;
  logic [BRAM_AWIDTH-1:0]    slot;
  logic [BRAM_AWIDTH-1:0]    base;
  logic [N_LABELS_WIDTH-1:0] n_eff;
  logic [N_LABELS_WIDTH-1:0] n_start;
  logic [N_LABELS_WIDTH-1:0] label;
  logic [N_LABELS_WIDTH-1:0] rd_label;
  logic [N_LABELS_WIDTH-1:0] best_lbl;
  logic [RES_WIDTH-1:0]      best_val;
  logic                      rd_valid;
  logic                      empty_hold;
  logic                      last_label;
  logic                      last_slot;

  assign last_label = (label == n_eff - N_LABELS_WIDTH'(1));
  assign last_slot  = (slot + BRAM_AWIDTH'(1) == n_slots_q);

  // Labels per slot for the configuration offered with i_start (0 -> 1, clip to N_LABELS)
  always_comb begin
    n_start = N_LABELS_WIDTH'(1);
    if (i_is_clf && (i_n_labels != '0)) begin
      if (i_n_labels > N_LABELS_WIDTH'(N_LABELS)) begin
        n_start = N_LABELS_WIDTH'(N_LABELS);
      end else begin
        n_start = i_n_labels;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and all state-derived outputs
  always_comb begin
    state_nxt    = state;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_bram_en    = 1'b0;
    o_bram_raddr = '0;
    o_res_vld    = 1'b0;
    o_res_slot   = '0;
    o_res_label  = '0;
    o_res_value  = '0;
    case (state)
      IDLE: begin
        if (i_start) begin
          state_nxt = (i_n_slots == '0) ? DONE : READ;
        end
      end
      READ: begin
        o_busy       = 1'b1;
        o_bram_en    = 1'b1;
        o_bram_raddr = base + BRAM_AWIDTH'(label);
        if (last_label) begin
          state_nxt = LAST;
        end
      end
      LAST: begin
        o_busy    = 1'b1;
        state_nxt = OUT;
      end
      OUT: begin
        o_busy      = 1'b1;
        o_res_vld   = 1'b1;
        o_res_slot  = slot;
        o_res_label = best_lbl;
        o_res_value = best_val;
        if (i_res_rdy) begin
          state_nxt = last_slot ? DONE : READ;
        end
      end
      DONE: begin
        o_busy = 1'b1;
        // An empty drain spends one extra cycle here so o_done lands two cycles after i_start
        if (!empty_hold) begin
          o_done    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Configuration latch, slot/label/base counters and read-return tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      n_slots_q  <= '0;
      n_eff      <= '0;
      slot       <= '0;
      label      <= '0;
      base       <= '0;
      rd_valid   <= 1'b0;
      rd_label   <= '0;
      empty_hold <= 1'b0;
    end else begin
      rd_valid   <= (state == READ);
      rd_label   <= label;
      empty_hold <= (state == IDLE) && i_start && (i_n_slots == '0);
      case (state)
        IDLE: begin
          if (i_start) begin
            n_slots_q <= i_n_slots;
            n_eff     <= n_start;
            slot      <= '0;
            label     <= '0;
            base      <= '0;
          end
        end
        READ: begin
          label <= last_label ? '0 : label + N_LABELS_WIDTH'(1);
        end
        OUT: begin
          if (i_res_rdy) begin
            base <= base + BRAM_AWIDTH'(n_eff);
            slot <= slot + BRAM_AWIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Running argmax: first word loads, later words replace only when strictly larger
  always_ff @(posedge clk) begin
    if (rst) begin
      best_val <= '0;
      best_lbl <= '0;
    end else if (rd_valid && ((rd_label == '0) || (i_bram_dout > best_val))) begin
      best_val <= i_bram_dout;
      best_lbl <= rd_label;
    end
  end

`ifdef VOTE_READER_CLEAR_EN
  logic [BRAM_AWIDTH-1:0] clr_addr;

  // Address issued this cycle is cleared next cycle, when its data returns
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_addr <= '0;
    end else begin
      clr_addr <= o_bram_raddr;
    end
  end

  assign o_bram_we    = rd_valid;
  assign o_bram_waddr = clr_addr;
`else
  assign o_bram_we    = 1'b0;
  assign o_bram_waddr = '0;
`endif
  assign o_bram_din = '0;

endmodule
`default_nettype wire

// File: tb/tb_vote_result_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_vote_result_reader
// Purpose  : Directed bench for vote_result_reader with a BRAM model and a
//            slot-level reference model checked every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vote_result_reader;
  localparam int AW   = 14;
  localparam int DW   = 16;
  localparam int LW   = 4;
  localparam int NL   = 10;
  localparam int MEMD = 1 << AW;
`ifdef VOTE_READER_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic [AW-1:0] i_n_slots;
  logic [LW-1:0] i_n_labels;
  logic          i_is_clf;
  logic          o_busy, o_done, o_bram_en, o_bram_we, o_res_vld, i_res_rdy;
  logic [AW-1:0] o_bram_raddr, o_bram_waddr, o_res_slot;
  logic [DW-1:0] bram_dout, o_bram_din, o_res_value;
  logic [LW-1:0] o_res_label;

  vote_result_reader dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_n_slots(i_n_slots),
    .i_n_labels(i_n_labels), .i_is_clf(i_is_clf), .o_busy(o_busy), .o_done(o_done),
    .o_bram_en(o_bram_en), .o_bram_raddr(o_bram_raddr), .i_bram_dout(bram_dout),
    .o_bram_we(o_bram_we), .o_bram_waddr(o_bram_waddr), .o_bram_din(o_bram_din),
    .o_res_vld(o_res_vld), .i_res_rdy(i_res_rdy), .o_res_slot(o_res_slot),
    .o_res_label(o_res_label), .o_res_value(o_res_value)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model: port A read (1-cycle latency), port B write, bench load/clear port
  logic [DW-1:0] mem [MEMD];
  logic          bk_clr = 1'b0, bk_we = 1'b0;
  logic [AW-1:0] bk_addr = '0;
  logic [DW-1:0] bk_data = '0;
  always @(posedge clk) begin
    if (bk_clr) begin
      for (int i = 0; i < MEMD; i++) mem[i] <= '0;
    end else if (bk_we) begin
      mem[bk_addr] <= bk_data;
    end
    if (o_bram_we) mem[o_bram_waddr] <= o_bram_din;
    if (o_bram_en) bram_dout <= mem[o_bram_raddr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference model state: slot-level view of one drain
  bit            mon_on = 1'b0;
  int            m_s = -1, m_n = 1, m_nslots = 0, m_slot = 0, m_entry = 0;
  int            m_done_cyc = -1, m_kill = 1 << 30;
  logic [DW-1:0] exp_val [8];
  logic [LW-1:0] exp_lbl [8];
  bit            p_en = 1'b0;
  int            p_addr = 0;
  int            obs_n = 0, en_count = 0, we_count = 0, done_obs = -1, hs_last = -1;
  logic [AW-1:0] obs_slot [8];
  logic [LW-1:0] obs_lbl  [8];
  logic [DW-1:0] obs_val  [8];

  // Compare process: every cycle the DUT is checked against the model
  always @(negedge clk) begin
    if (mon_on) begin
      bit live, e_en, e_vld, e_we;
      int e_addr;
      live   = (m_s >= 0) && (cyc > m_s) && (cyc < m_kill) &&
               ((m_done_cyc < 0) || (cyc <= m_done_cyc));
      e_en   = live && (m_slot < m_nslots) && (cyc >= m_entry) && (cyc < m_entry + m_n);
      e_addr = (m_slot * m_n + (cyc - m_entry)) % MEMD;
      e_vld  = live && (m_slot < m_nslots) && (cyc >= m_entry + m_n + 1);
      e_we   = CLR && p_en && (cyc < m_kill);
      chk("busy", 32'(o_busy), 32'(live));
      chk("done", 32'(o_done), 32'(live && (cyc == m_done_cyc)));
      chk("bram_en", 32'(o_bram_en), 32'(e_en));
      if (e_en) chk("raddr", 32'(o_bram_raddr), 32'(e_addr));
      chk("bram_we", 32'(o_bram_we), 32'(e_we));
      if (e_we) chk("waddr", 32'(o_bram_waddr), 32'(p_addr));
      chk("bram_din", 32'(o_bram_din), 32'd0);
      if (o_bram_en && o_bram_we) chk("rw_same_addr", 32'(o_bram_raddr != o_bram_waddr), 32'd1);
      chk("res_vld", 32'(o_res_vld), 32'(e_vld));
      if (e_vld) begin
        chk("res_slot", 32'(o_res_slot), 32'(m_slot));
        chk("res_label", 32'(o_res_label), 32'(exp_lbl[m_slot]));
        chk("res_value", 32'(o_res_value), 32'(exp_val[m_slot]));
      end
      if (o_bram_en) en_count++;
      if (o_bram_we) we_count++;
      if (o_done) done_obs = cyc;
      p_en   = e_en;
      p_addr = e_addr;
      if (e_vld && i_res_rdy) begin
        if (obs_n < 8) begin
          obs_slot[obs_n] = o_res_slot;
          obs_lbl[obs_n]  = o_res_label;
          obs_val[obs_n]  = o_res_value;
        end
        obs_n++;
        hs_last = cyc;
        m_slot++;
        m_entry = cyc + 1;
        if (m_slot == m_nslots) m_done_cyc = cyc + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_clear();
    bk_clr = 1'b1;
    tick();
    bk_clr = 1'b0;
  endtask

  task automatic mem_load(input int a, input int d);
    bk_we = 1'b1; bk_addr = AW'(a); bk_data = DW'(d);
    tick();
    bk_we = 1'b0;
  endtask

  // Issue i_start and derive expected per-slot results from the current BRAM image
  task automatic start_drain(input int ns, input int nl, input bit clf, input bit rdy);
    int n;
    n = !clf ? 1 : (nl == 0) ? 1 : (nl > NL) ? NL : nl;
    for (int s = 0; s < ns && s < 8; s++) begin
      exp_val[s] = mem[(s * n) % MEMD];
      exp_lbl[s] = '0;
      for (int k = 1; k < n; k++) begin
        if (mem[(s * n + k) % MEMD] > exp_val[s]) begin
          exp_val[s] = mem[(s * n + k) % MEMD];
          exp_lbl[s] = LW'(k);
        end
      end
    end
    i_n_slots = AW'(ns); i_n_labels = LW'(nl); i_is_clf = clf; i_res_rdy = rdy;
    i_start = 1'b1;
    obs_n = 0; en_count = 0; we_count = 0; done_obs = -1; hs_last = -1;
    m_s = cyc; m_n = n; m_nslots = ns; m_slot = 0; m_entry = cyc + 1;
    m_done_cyc = (ns == 0) ? cyc + 2 : -1; m_kill = 1 << 30;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_vld(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (o_res_vld) seen = 1'b1;
    end
    chk("vld_timeout", 32'(seen), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (o_done) seen = 1'b1;
    end
    chk("done_timeout", 32'(seen), 32'd1);
    tick();
  endtask

  task automatic check_all_zero(input string pfx);
    chk({pfx, "_busy"}, 32'(o_busy), 32'd0);
    chk({pfx, "_done"}, 32'(o_done), 32'd0);
    chk({pfx, "_en"}, 32'(o_bram_en), 32'd0);
    chk({pfx, "_raddr"}, 32'(o_bram_raddr), 32'd0);
    chk({pfx, "_we"}, 32'(o_bram_we), 32'd0);
    chk({pfx, "_waddr"}, 32'(o_bram_waddr), 32'd0);
    chk({pfx, "_vld"}, 32'(o_res_vld), 32'd0);
    chk({pfx, "_slot"}, 32'(o_res_slot), 32'd0);
    chk({pfx, "_label"}, 32'(o_res_label), 32'd0);
    chk({pfx, "_value"}, 32'(o_res_value), 32'd0);
  endtask

  int t1_img [6] = '{5, 9, 2, 7, 7, 1};
  int t5_img [9] = '{4, 8, 6, 3, 2, 5, 9, 1, 7};

  initial begin
    rst = 1'b1; i_start = 1'b0; i_n_slots = '0; i_n_labels = '0; i_is_clf = 1'b0;
    i_res_rdy = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_all_zero("reset");
    mon_on = 1'b1;

    // Classification argmax with a stalled sink
    mem_clear();
    for (int i = 0; i < 6; i++) mem_load(i, t1_img[i]);
    start_drain(2, 3, 1'b1, 1'b0);
    wait_vld(50);
    repeat (4) tick();
    i_res_rdy = 1'b1;
    wait_done(100);
    chk("clf_count", 32'(obs_n), 32'd2);
    chk("clf_s0_slot", 32'(obs_slot[0]), 32'd0);
    chk("clf_s0_label", 32'(obs_lbl[0]), 32'd1);
    chk("clf_s0_value", 32'(obs_val[0]), 32'd9);
    chk("clf_s1_slot", 32'(obs_slot[1]), 32'd1);
    chk("clf_s1_label", 32'(obs_lbl[1]), 32'd0);
    chk("clf_s1_value", 32'(obs_val[1]), 32'd7);
    chk("clf_reads", 32'(en_count), 32'd6);
    for (int i = 0; i < 6; i++) chk("clf_mem_after", 32'(mem[i]), CLR ? 32'd0 : 32'(t1_img[i]));

    // Regression
    mem_clear();
    mem_load(0, 100); mem_load(1, 16'hFFFF); mem_load(2, 3);
    start_drain(3, 7, 1'b0, 1'b1);
    wait_done(100);
    chk("reg_count", 32'(obs_n), 32'd3);
    chk("reg_v0", 32'(obs_val[0]), 32'd100);
    chk("reg_v1", 32'(obs_val[1]), 32'hFFFF);
    chk("reg_v2", 32'(obs_val[2]), 32'd3);
    chk("reg_l1", 32'(obs_lbl[1]), 32'd0);
    chk("reg_done_lat", 32'(done_obs - hs_last), 32'd1);

    // Empty drain
    start_drain(0, 3, 1'b1, 1'b1);
    wait_done(20);
    chk("empty_done_at", 32'(done_obs - m_s), 32'd2);
    chk("empty_results", 32'(obs_n), 32'd0);
    chk("empty_writes", 32'(we_count), 32'd0);

    // Label-count clipping
    start_drain(2, 0, 1'b1, 1'b1);
    wait_done(100);
    chk("clip0_reads", 32'(en_count), 32'd2);
    start_drain(2, 12, 1'b1, 1'b1);
    wait_done(100);
    chk("clip12_reads", 32'(en_count), 32'd20);

    // Reset in the first READ cycle of slot 1
    mem_clear();
    for (int i = 0; i < 9; i++) mem_load(i, t5_img[i]);
    start_drain(3, 3, 1'b1, 1'b1);
    wait_vld(50);
    tick();
    rst = 1'b1;
    m_kill = cyc + 1;
    tick();
    rst = 1'b0;
    check_all_zero("midrst");
    for (int i = 0; i < 3; i++) chk("midrst_s0_mem", 32'(mem[i]), CLR ? 32'd0 : 32'(t5_img[i]));
    for (int i = 3; i < 9; i++) chk("midrst_rest_mem", 32'(mem[i]), 32'(t5_img[i]));
    start_drain(1, 0, 1'b0, 1'b1);
    wait_done(50);
    chk("post_rst_count", 32'(obs_n), 32'd1);
    chk("post_rst_value", 32'(obs_val[0]), CLR ? 32'd0 : 32'd4);

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/vote_result_reader.md
# vote_result_reader

Drains the vote BRAM that the vote buffer fills, one vote slot at a time, and turns it into final per-sample predictions. Classification: argmax label over the slot's `i_n_labels` counters. Regression: the raw accumulated sum. Each location is cleared after it is read, so the BRAM is zero for the next inference batch. The block sits on the PL-side read/write ports of the vote BRAM, where the PS otherwise reads. It streams results over a valid/ready interface toward the result DMA/FIFO.

## Interface
Parameters:
- `N_LABELS`, 10: maximum number of labels.
- `N_LABELS_WIDTH`, 4: width of label indices and of `i_n_labels`.
- `RES_WIDTH`, 16: width of a vote counter or regression sum.
- `BRAM_AWIDTH`, 14: vote BRAM word-address width.
- `BRAM_DWIDTH`, 16: vote BRAM data width; must equal `RES_WIDTH`.

Ports (one clock; reset is synchronous and active-high):
- `clk`, in, 1: single clock for all logic and both BRAM ports.
- `rst`, in, 1: synchronous, active-high reset.
- `i_start`, in, 1: one-cycle request to begin a drain; ignored while `o_busy` is high.
- `i_n_slots`, in, `BRAM_AWIDTH`: number of vote slots to drain; sampled on `i_start`.
- `i_n_labels`, in, `N_LABELS_WIDTH`: labels per slot; sampled on `i_start`.
- `i_is_clf`, in, 1: 1 selects classification, 0 selects regression; sampled on `i_start`.
- `o_busy`, out, 1: high while a drain is in progress.
- `o_done`, out, 1: one-cycle pulse when a drain completes.
- `o_bram_en`, out, 1: read enable for BRAM port A.
- `o_bram_raddr`, out, `BRAM_AWIDTH`: read address for port A.
- `i_bram_dout`, in, `BRAM_DWIDTH`: port A read data, valid exactly 1 cycle after the address.
- `o_bram_we`, out, 1: write enable for BRAM port B (clear).
- `o_bram_waddr`, out, `BRAM_AWIDTH`: write address for port B.
- `o_bram_din`, out, `BRAM_DWIDTH`: write data for port B; always 0.
- `o_res_vld`, out, 1: result valid.
- `i_res_rdy`, in, 1: downstream ready.
- `o_res_slot`, out, `BRAM_AWIDTH`: vote slot index of the result.
- `o_res_label`, out, `N_LABELS_WIDTH`: argmax label; 0 in regression mode.
- `o_res_value`, out, `RES_WIDTH`: winning count (classification) or sum (regression).

## Operation
- FSM states: IDLE, READ, LAST, OUT, DONE.
- IDLE:
  - On `i_start`, latch the configuration and clear the slot counter, label counter and base address.
  - If `i_n_slots`=0, go to DONE; otherwise go to READ.
- Effective label count n:
  - Regression: n = 1.
  - Classification: n = `i_n_labels`, with 0 treated as 1 and values above `N_LABELS` clipped to `N_LABELS`.
- READ:
  - Assert `o_bram_en` with `o_bram_raddr` = base + label, label = 0..n-1 on consecutive cycles.
  - After issuing label n-1, go to LAST.
- Read-data handling, each cycle data returns:
  - First word of a slot: load best value and best label.
  - Later words: update only when data is strictly greater than the current best. Ties keep the lowest label.
- LAST: absorb the final data word, then go to OUT.
- OUT:
  - Hold `o_res_vld` and all result fields stable until `i_res_rdy`.
  - On handshake: base += n (wraps modulo 2^`BRAM_AWIDTH`), slot += 1.
  - Go to DONE after the last slot; otherwise go to READ.
- DONE: pulse `o_done` for 1 cycle, then go to IDLE.
- Address generation: addresses come from a running base adder; no multiplier.
- Reset value of every output is 0.
- Reset mid-drain: return to IDLE immediately. Counters already cleared stay 0; the remainder is left untouched.

## Timing
- `i_start` at cycle s:
  - `o_busy`=1 and the first read address are presented at s+1.
- Per classification slot entering READ at t:
  - Address k is at t+k.
  - Data k is at t+k+1.
  - `o_res_vld` rises at t+n+1.
- Regression: `o_res_vld` rises at t+2.
- Handshake at cycle h: the next slot's READ begins at h+1, so there are no back-to-back results.
- Clear writes: each cycle data returns, `o_bram_we`=1 with `o_bram_waddr` = the address issued the previous cycle.
  - A read and the clear write never target the same address in the same cycle.
- `o_done`: high exactly 1 cycle after the last handshake.
  - For `i_n_slots`=0, high at s+2 with no results.
- `o_busy` falls together with `o_done`.

## Configuration
- `VOTE_READER_CLEAR_EN` defined: clear-on-read writes are generated as described above.
- `VOTE_READER_CLEAR_EN` undefined:
  - `o_bram_we`, `o_bram_waddr` and `o_bram_din` are tied to 0.
  - BRAM contents are preserved; all read, handshake and timing behaviour is unchanged.

## Test plan
- Classification argmax with a stalled sink:
  - Stimulus: n_labels=3, 2 slots, BRAM = {5,9,2, 7,7,1}, `i_res_rdy` held 0 for 4 cycles.
  - Required: results (slot0, label1, 9) then (slot1, label0, 7) on the tie; fields stable while stalled; all 6 words read back 0 afterwards.
- Regression:
  - Stimulus: 3 slots with sums {100, 0xFFFF, 3}, `i_res_rdy`=1.
  - Required: values 100, 0xFFFF, 3 with label 0; `o_res_vld` 2 cycles after each READ entry; `o_done` 1 cycle after the third handshake.
- Empty drain:
  - Stimulus: `i_n_slots`=0.
  - Required: no `o_res_vld`, no BRAM write, `o_done` at s+2.
- Label-count clipping:
  - Stimulus: `i_n_labels`=0, then `i_n_labels`=12.
  - Required: 1 and 10 addresses issued per slot respectively.
- Reset mid-drain:
  - Stimulus: assert `rst` during READ of slot 1.
  - Required: all outputs 0 next cycle; slot-0 locations 0, slot-1 and later unchanged; `i_start` accepted afterwards.
- Macro off:
  - Build without `VOTE_READER_CLEAR_EN`, rerun the classification argmax test.
  - Required: identical results; BRAM still holds {5,9,2, 7,7,1}.
